// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the register file's single write port between two writeback
//   sources. Each requester owns a one-entry pending slot behind a
//   valid/ready handshake. A round-robin arbiter (with an age override for
//   same-address collisions) drains one slot per cycle into a registered
//   write stage that drives Write_Reg/W_Addr/W_Data.
//
//   Optional feature: define REGFILE_BYPASS_EN to forward the in-flight
//   write stage to the read ports; otherwise the read data passes through.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   req_valid_x/addr_x/data_x       requester x write offer
//   req_ready_x                     slot x can accept this cycle
//   Write_Reg, W_Addr, W_Data       registered register-file write port
//   grant                           one-hot slot drained this cycle (combinational)
//   R_Addr_A/B, rf_data_a/b         read addresses and raw register-file read data
//   rd_data_a/b                     read data seen by consumers
module regfile_wr_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_data_0,
    output logic              req_ready_0,
    input  logic              req_valid_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_data_1,
    output logic              req_ready_1,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic [1:0]        grant,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    // Pending slots
    logic              slot_valid_0_q, slot_valid_0_d;
    logic              slot_valid_1_q, slot_valid_1_d;
    logic [ADDR_W-1:0] slot_addr_0_q, slot_addr_1_q;
    logic [DATA_W-1:0] slot_data_0_q, slot_data_1_q;

    // rr_q: slot favoured when both compete with different addresses.
    // age_q: index of the older slot when both are valid.
    logic rr_q, rr_d;
    logic age_q, age_d;

    // Write stage
    logic              write_reg_q, write_reg_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;

    logic              load_0, load_1;
    logic              stay_0, stay_1;
    logic              both_valid;
    logic              gsel;
    logic              any_grant;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    // Arbitration looks only at slot state, never at incoming requests.
    always_comb begin
        grant      = 2'b00;
        gsel       = 1'b0;
        both_valid = slot_valid_0_q && slot_valid_1_q;
        if (both_valid) begin
            // Same destination: older write must land first.
            gsel  = (slot_addr_0_q == slot_addr_1_q) ? age_q : rr_q;
            grant = gsel ? 2'b10 : 2'b01;
        end else if (slot_valid_0_q) begin
            gsel  = 1'b0;
            grant = 2'b01;
        end else if (slot_valid_1_q) begin
            gsel  = 1'b1;
            grant = 2'b10;
        end
    end

    assign any_grant = |grant;
    assign g_addr    = gsel ? slot_addr_1_q : slot_addr_0_q;
    assign g_data    = gsel ? slot_data_1_q : slot_data_0_q;

    // A draining slot can refill in the same cycle.
    assign req_ready_0 = !slot_valid_0_q || grant[0];
    assign req_ready_1 = !slot_valid_1_q || grant[1];

    assign load_0 = req_valid_0 && req_ready_0;
    assign load_1 = req_valid_1 && req_ready_1;
    // Slot keeps its current (older) contents across the edge.
    assign stay_0 = slot_valid_0_q && !grant[0];
    assign stay_1 = slot_valid_1_q && !grant[1];

    always_comb begin
        slot_valid_0_d = load_0 || stay_0;
        slot_valid_1_d = load_1 || stay_1;

        rr_d = both_valid ? ~gsel : rr_q;

        age_d = age_q;
        if (load_0 && load_1) begin
            age_d = 1'b0;          // simultaneous load: slot 0 counts as older
        end else if (stay_0 && load_1) begin
            age_d = 1'b0;
        end else if (stay_1 && load_0) begin
            age_d = 1'b1;
        end

        write_reg_d = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        if (any_grant) begin
            // Register 0 is hard-wired zero: drain the slot but suppress the write.
            write_reg_d = (g_addr != '0);
            w_addr_d    = g_addr;
            w_data_d    = g_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_0_q <= 1'b0;
            slot_valid_1_q <= 1'b0;
            rr_q           <= 1'b0;
            age_q          <= 1'b0;
            write_reg_q    <= 1'b0;
            w_addr_q       <= '0;
            w_data_q       <= '0;
        end else begin
            slot_valid_0_q <= slot_valid_0_d;
            slot_valid_1_q <= slot_valid_1_d;
            rr_q           <= rr_d;
            age_q          <= age_d;
            write_reg_q    <= write_reg_d;
            w_addr_q       <= w_addr_d;
            w_data_q       <= w_data_d;
        end
    end

    // Slot payloads need no reset; they are qualified by the valids.
    always_ff @(posedge clk) begin
        if (load_0) begin
            slot_addr_0_q <= req_addr_0;
            slot_data_0_q <= req_data_0;
        end
        if (load_1) begin
            slot_addr_1_q <= req_addr_1;
            slot_data_1_q <= req_data_1;
        end
    end

    assign Write_Reg = write_reg_q;
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;

`ifdef REGFILE_BYPASS_EN
    // Only the write stage is forwarded; pending slots are not yet architectural.
    logic fwd_a, fwd_b;
    assign fwd_a     = write_reg_q && (w_addr_q != '0) && (R_Addr_A == w_addr_q);
    assign fwd_b     = write_reg_q && (w_addr_q != '0) && (R_Addr_B == w_addr_q);
    assign rd_data_a = fwd_a ? w_data_q : rf_data_a;
    assign rd_data_b = fwd_b ? w_data_q : rf_data_b;
`else
    assign rd_data_a = rf_data_a;
    assign rd_data_b = rf_data_b;
`endif

endmodule
